clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-setting controller for the clock calendar. Consumes the four debounced front-panel keys and the matrix-keypad value strobe, and sequences entry of a new HH:MM:SS time as six BCD digits. On commit it snapshots the result into the timekeeping counter with a one-cycle load strobe; it also owns the display-page selection.

## Interface
- TIMEOUT_CYC, 500_000_000: idle cycles in edit before an automatic cancel (10 s at 50 MHz).
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- mode_key  in  1  debounced mode key; active-low level.
- move_key  in  1  debounced move key; active-low level.
- add_key  in  1  debounced add key; active-low level.
- switch_key  in  1  debounced display-select key; active-low level.
- key_value  in  4  keypad code, 0..15; valid only when value_en is high.
- value_en  in  1  one-cycle keypad strobe.
- cur_time  in  24  running time as BCD {Ht,Hu,Mt,Mu,St,Su}.
- set_time  out  24  edited time as BCD, same packing as cur_time.
- time_load  out  1  one-cycle strobe; set_time is valid while it is high.
- run_en  out  1  high means the time counter may count.
- edit_active  out  1  high while in EDIT.
- cursor  out  3  edited digit: 0=Ht, 1=Hu, 2=Mt, 3=Mu, 4=St, 5=Su.
- blink_mask  out  6  one-hot of cursor while editing (bit5=Ht, bit0=Su); 0 otherwise.
- disp_sel  out  2  display page 0..2.

## Operation
- Press detection: each key uses a registered previous level. A press is a 1→0 transition and produces one internal pulse per press. Previous-level registers reset to 1, so no press is detected out of reset.
- Main FSM states: RUN, EDIT, COMMIT.
- RUN: run_en=1.
  - mode press → EDIT. On entry, cur_time is copied into the edit digits, cursor=0, and the idle counter is cleared.
- EDIT: run_en=0.
  - Event priority within one cycle: mode > keypad (value_en) > move > add. Only the highest-priority event acts; lower ones in that cycle are dropped.
  - mode press → COMMIT.
  - keypad code 10 → COMMIT.
  - keypad code 11 → RUN with no load (cancel).
  - keypad code 0..9: written to the digit at cursor if it is within that digit's limit, then cursor advances mod 6. An illegal value is ignored and the cursor does not move. Codes 12..15 are ignored.
  - move press: cursor=(cursor+1) mod 6.
  - add press: the digit at cursor increments and wraps to 0 above its limit.
  - Digit limits: Ht 0..2; Hu 0..9, or 0..3 when Ht=2; Mt and St 0..5; Mu and Su 0..9.
  - Hour clamp: whenever Ht becomes 2 (by add or by keypad) and Hu>3, Hu is forced to 3 in the same update.
  - Any accepted event clears the idle counter.
  - Idle counter reaching TIMEOUT_CYC-1 → RUN with no load.
- COMMIT: lasts one cycle. time_load=1, set_time=edit digits, then → RUN.
- switch press: in every state, disp_sel steps 0→1→2→0. Independent of the FSM.
- set_time holds its last value outside COMMIT.

## Timing
- Reset values: state RUN, run_en=1, time_load=0, edit_active=0, set_time=0, cursor=0, blink_mask=0, disp_sel=0, idle counter 0.
- Key latency: a key first sampled low at edge k produces the press pulse at edge k+1. State and output updates are visible after edge k+2.
- Keypad latency: value_en sampled high at edge k; edit digits and cursor are updated after edge k+1.
- COMMIT timing: time_load is high for exactly one cycle, beginning the cycle after the commit event registers. run_en returns to 1 in the cycle after time_load.
- Reset mid-EDIT: immediate return to RUN, no time_load, edit digits lost.
- A key held low produces one press only. Release followed by re-press needs a fresh 1→0 transition.
- Idle counter width: $clog2(TIMEOUT_CYC). It saturates and does not wrap.

## Test plan
- Reset, then pulse mode_key with cur_time=12:34:56 → edit_active=1, blink_mask=6'b100000, run_en=0. Press mode again → one-cycle time_load with set_time=0x123456, then run_en=1.
- In EDIT from 00:00:00, keypad 2,3,5,9,5,9 then code 10 → set_time=0x235959, cursor wraps to 0 before commit.
- From 19:00:00, cursor=0, add press → Ht=2 and Hu clamped to 3 (0x230000). Keypad 9 at cursor=1 ignored, cursor stays 1. Add on Mt at 5 → wraps to 0.
- Mode press and value_en (code 7) in the same cycle in EDIT → COMMIT. Digit unchanged.
- TIMEOUT_CYC=100, enter EDIT, no activity → returns to RUN after 100 idle cycles, time_load never asserted. Keypad 11 mid-edit → RUN, no load.
- Four switch presses from reset → disp_sel 1,2,0,1. Hold switch_key low 1000 cycles → single step. Assert rst_n low during EDIT → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Front-panel bundle for the time-setting controller.
//   Keys (active-low levels): mode_key, move_key, add_key, switch_key
//   Keypad: key_value[3:0], qualified by the one-cycle strobe value_en
//   cur_time[23:0]: running BCD time {Ht,Hu,Mt,Mu,St,Su}
//   Results: set_time, time_load, run_en, edit_active, cursor, blink_mask, disp_sel
// The master modport belongs to the panel/counter side; the slave modport is the controller.
interface clock_set_ctrl_if;
  logic        mode_key;
  logic        move_key;
  logic        add_key;
  logic        switch_key;
  logic [3:0]  key_value;
  logic        value_en;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        time_load;
  logic        run_en;
  logic        edit_active;
  logic [2:0]  cursor;
  logic [5:0]  blink_mask;
  logic [1:0]  disp_sel;

  modport master (
    output mode_key, move_key, add_key, switch_key, key_value, value_en, cur_time,
    input  set_time, time_load, run_en, edit_active, cursor, blink_mask, disp_sel
  );

  modport slave (
    input  mode_key, move_key, add_key, switch_key, key_value, value_en, cur_time,
    output set_time, time_load, run_en, edit_active, cursor, blink_mask, disp_sel
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the clock calendar.
// Detects key presses, sequences entry of six BCD digits (HH:MM:SS) in EDIT, and on commit
// presents the edited time on set_time with a one-cycle time_load strobe. Also steps the
// display page on each switch press, independently of the main FSM.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    clock_set_ctrl_if.slave (keys, keypad, cur_time in; set_time/strobes/status out)
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input logic            clk,
  input logic            rst_n,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] IdleLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StRun, StEdit, StCommit} state_e;

  // Key bit order: 0=mode, 1=move, 2=add, 3=switch
  logic [3:0] key_lvl_q, key_prev_q, press_q;
  logic       val_en_q;
  logic [3:0] val_q;

  state_e            state_q, state_d;
  logic [5:0][3:0]   dig_q, dig_d;   // dig[5]=Ht ... dig[0]=Su, matches set_time packing
  logic [2:0]        cursor_q, cursor_d;
  logic [CntW-1:0]   idle_q, idle_d;
  logic [23:0]       set_q, set_d;
  logic [1:0]        disp_q, disp_d;

  logic mode_p, move_p, add_p, switch_p;
  assign mode_p   = press_q[0];
  assign move_p   = press_q[1];
  assign add_p    = press_q[2];
  assign switch_p = press_q[3];

  // Upper bound of the digit at cursor position pos, given the current tens-of-hours.
  function automatic logic [3:0] dig_limit(input logic [2:0] pos, input logic [3:0] ht);
    logic [3:0] lim;
    case (pos)
      3'd0:        lim = 4'd2;
      3'd1:        lim = (ht == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4:  lim = 4'd5;
      default:     lim = 4'd9;
    endcase
    return lim;
  endfunction

  function automatic logic [2:0] cursor_next(input logic [2:0] c);
    return (c == 3'd5) ? 3'd0 : c + 3'd1;
  endfunction

  // Input sampling and 1->0 press detection; a held key yields a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_lvl_q  <= 4'hF;
      key_prev_q <= 4'hF;
      press_q    <= 4'h0;
      val_en_q   <= 1'b0;
      val_q      <= 4'h0;
    end else begin
      key_lvl_q  <= {bus.switch_key, bus.add_key, bus.move_key, bus.mode_key};
      key_prev_q <= key_lvl_q;
      press_q    <= key_prev_q & ~key_lvl_q;
      val_en_q   <= bus.value_en;
      val_q      <= bus.key_value;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: if (mode_p) state_d = StEdit;
      StEdit: begin
        if (mode_p) begin
          state_d = StCommit;
        end else if (val_en_q) begin
          if (val_q == 4'd10)      state_d = StCommit;
          else if (val_q == 4'd11) state_d = StRun;
        end else if (!move_p && !add_p && idle_q == IdleLast) begin
          state_d = StRun;
        end
      end
      StCommit: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.run_en      = (state_q == StRun);
    bus.edit_active = (state_q == StEdit);
    bus.time_load   = (state_q == StCommit);
    bus.blink_mask  = (state_q == StEdit) ? (6'b100000 >> cursor_q) : 6'b000000;
    bus.set_time    = set_q;
    bus.cursor      = cursor_q;
    bus.disp_sel    = disp_q;
  end

  // Edit datapath: digits, cursor, idle counter, commit snapshot, display page.
  always_comb begin
    logic [2:0] idx;
    logic [3:0] cur_dig;
    logic [3:0] new_dig;
    dig_d    = dig_q;
    cursor_d = cursor_q;
    idle_d   = idle_q;
    set_d    = set_q;
    disp_d   = disp_q;
    idx      = 3'd5 - cursor_q;
    cur_dig  = dig_q[idx];
    new_dig  = 4'd0;

    unique case (state_q)
      StRun: begin
        if (mode_p) begin
          dig_d    = bus.cur_time;
          cursor_d = 3'd0;
          idle_d   = '0;
        end
      end
      StEdit: begin
        if (mode_p) begin
          idle_d = '0;
        end else if (val_en_q) begin
          if (val_q <= 4'd9) begin
            if (val_q <= dig_limit(cursor_q, dig_q[5])) begin
              dig_d[idx] = val_q;
              // Ht reaching 2 drags an out-of-range Hu down to 3 in the same update.
              if (cursor_q == 3'd0 && val_q == 4'd2 && dig_q[4] > 4'd3) dig_d[4] = 4'd3;
              cursor_d = cursor_next(cursor_q);
              idle_d   = '0;
            end
          end else if (val_q == 4'd10 || val_q == 4'd11) begin
            idle_d = '0;
          end
        end else if (move_p) begin
          cursor_d = cursor_next(cursor_q);
          idle_d   = '0;
        end else if (add_p) begin
          new_dig    = (cur_dig >= dig_limit(cursor_q, dig_q[5])) ? 4'd0 : cur_dig + 4'd1;
          dig_d[idx] = new_dig;
          if (cursor_q == 3'd0 && new_dig == 4'd2 && dig_q[4] > 4'd3) dig_d[4] = 4'd3;
          idle_d = '0;
        end else if (idle_q != IdleLast) begin
          idle_d = idle_q + CntW'(1);
        end
      end
      default: ;
    endcase

    if (state_d == StCommit) set_d = dig_q;

    if (switch_p) disp_d = (disp_q == 2'd2) ? 2'd0 : disp_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q    <= '0;
      cursor_q <= 3'd0;
      idle_q   <= '0;
      set_q    <= 24'h0;
      disp_q   <= 2'd0;
    end else begin
      dig_q    <= dig_d;
      cursor_q <= cursor_d;
      idle_q   <= idle_d;
      set_q    <= set_d;
      disp_q   <= disp_d;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [23:0] exp_q[$];

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // k: 0=mode 1=move 2=add 3=switch. Returns just after the edge where the effect lands.
  task automatic press_key(input int k);
    case (k)
      0: bus.mode_key = 1'b0;
      1: bus.move_key = 1'b0;
      2: bus.add_key = 1'b0;
      default: bus.switch_key = 1'b0;
    endcase
    tick(1);
    bus.mode_key = 1'b1; bus.move_key = 1'b1; bus.add_key = 1'b1; bus.switch_key = 1'b1;
    tick(2);
  endtask

  task automatic keypad(input logic [3:0] v);
    bus.key_value = v;
    bus.value_en  = 1'b1;
    tick(1);
    bus.value_en  = 1'b0;
    tick(1);
  endtask

  // Scoreboard monitor: every time_load pops one expected set_time.
  initial begin
    logic        prev_load;
    logic [23:0] e;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_load) check("run_en_after_load", {31'd0, bus.run_en}, 32'd1);
        if (bus.time_load) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_load: got set_time %0h expected no load at %0t",
                     bus.set_time, $time);
          end else begin
            e = exp_q.pop_front();
            check("set_time", {8'd0, bus.set_time}, {8'd0, e});
            check("run_en_during_load", {31'd0, bus.run_en}, 32'd0);
          end
        end
        prev_load = bus.time_load;
      end else begin
        prev_load = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run_en"},      {31'd0, bus.run_en},      32'd1);
    check({tag, "_time_load"},   {31'd0, bus.time_load},   32'd0);
    check({tag, "_edit_active"}, {31'd0, bus.edit_active}, 32'd0);
    check({tag, "_set_time"},    {8'd0, bus.set_time},     32'd0);
    check({tag, "_cursor"},      {29'd0, bus.cursor},      32'd0);
    check({tag, "_blink_mask"},  {26'd0, bus.blink_mask},  32'd0);
    check({tag, "_disp_sel"},    {30'd0, bus.disp_sel},    32'd0);
  endtask

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.mode_key = 1'b1; bus.move_key = 1'b1; bus.add_key = 1'b1; bus.switch_key = 1'b1;
    bus.key_value = 4'd0; bus.value_en = 1'b0; bus.cur_time = 24'h0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Enter EDIT from 12:34:56 and commit unchanged.
    bus.cur_time = 24'h123456;
    press_key(0);
    check("enter_edit_active", {31'd0, bus.edit_active}, 32'd1);
    check("enter_blink", {26'd0, bus.blink_mask}, 32'h20);
    check("enter_run_en", {31'd0, bus.run_en}, 32'd0);
    exp_q.push_back(24'h123456);
    press_key(0);
    tick(2);
    check("post_commit_run_en", {31'd0, bus.run_en}, 32'd1);

    // Keypad entry of 23:59:59, commit with code 10.
    bus.cur_time = 24'h000000;
    press_key(0);
    keypad(4'd2);
    check("kp_cursor1", {29'd0, bus.cursor}, 32'd1);
    check("kp_blink1", {26'd0, bus.blink_mask}, 32'h10);
    keypad(4'd3); keypad(4'd5); keypad(4'd9); keypad(4'd5); keypad(4'd9);
    check("kp_cursor_wrap", {29'd0, bus.cursor}, 32'd0);
    exp_q.push_back(24'h235959);
    keypad(4'd10);
    tick(2);

    // Hour clamp, illegal keypad value, add wrap on Mt.
    bus.cur_time = 24'h190000;
    press_key(0);
    press_key(2);                 // Ht 1->2, Hu 9 clamped to 3
    press_key(1);
    keypad(4'd9);                 // Hu limit is 3: ignored
    check("illegal_cursor_stays", {29'd0, bus.cursor}, 32'd1);
    press_key(1);
    keypad(4'd5);                 // Mt=5
    for (int i = 0; i < 5; i++) press_key(1);
    check("move_wrap_cursor", {29'd0, bus.cursor}, 32'd2);
    check("move_wrap_blink", {26'd0, bus.blink_mask}, 32'h08);
    press_key(2);                 // Mt 5 -> 0
    press_key(2);                 // Mt 0 -> 1
    exp_q.push_back(24'h231000);
    press_key(0);
    tick(2);

    // Mode press and keypad 7 acting in the same cycle: mode wins, digit untouched.
    bus.cur_time = 24'h101010;
    press_key(0);
    press_key(1);
    exp_q.push_back(24'h101010);
    bus.mode_key = 1'b0;
    tick(1);
    bus.mode_key = 1'b1;
    bus.key_value = 4'd7;
    bus.value_en = 1'b1;
    tick(1);
    bus.value_en = 1'b0;
    tick(1);
    check("same_cycle_cursor", {29'd0, bus.cursor}, 32'd1);
    tick(2);

    // Idle timeout: 100 cycles, no load.
    press_key(0);
    n = 0;
    while (bus.edit_active && n < 200) begin
      tick(1);
      n++;
    end
    check("timeout_cycles", n, 32'd100);
    check("timeout_run_en", {31'd0, bus.run_en}, 32'd1);
    tick(2);

    // Cancel with keypad 11.
    press_key(0);
    keypad(4'd3);
    keypad(4'd11);
    check("cancel_edit_active", {31'd0, bus.edit_active}, 32'd0);
    check("cancel_run_en", {31'd0, bus.run_en}, 32'd1);
    tick(3);

    // Display page stepping, including a long hold.
    press_key(3); check("disp_1", {30'd0, bus.disp_sel}, 32'd1);
    press_key(3); check("disp_2", {30'd0, bus.disp_sel}, 32'd2);
    press_key(3); check("disp_0", {30'd0, bus.disp_sel}, 32'd0);
    press_key(3); check("disp_1b", {30'd0, bus.disp_sel}, 32'd1);
    bus.switch_key = 1'b0;
    tick(1000);
    bus.switch_key = 1'b1;
    tick(3);
    check("disp_hold", {30'd0, bus.disp_sel}, 32'd2);

    // Asynchronous reset in the middle of EDIT.
    press_key(0);
    press_key(1);
    check("pre_reset_edit", {31'd0, bus.edit_active}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick(1);
    rst_n = 1'b1;
    tick(3);

    check("pending_loads", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
